// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Receive side of the hex-to-7-segment display path. It watches the multiplexed
// anode/segment bus and waits for each digit dwell to hold steady. It decodes the
// segment pattern back to a nibble, and publishes a full display word once every
// digit has been seen.
// Optional feature: define DP_CAPTURE_EN to capture the decimal point of each
// digit and present it on Dp_out. When it is undefined, Dp_out is tied to zero.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [NUM_DIGITS-1:0]   Anode_in,
  input  logic [7:0]              Seg_in,
  input  logic                    Err_clr,
  output logic [4*NUM_DIGITS-1:0] Value_out,
  output logic                    Valid_out,
  output logic [NUM_DIGITS-1:0]   Digit_mask,
  output logic                    Err_out,
  output logic [NUM_DIGITS-1:0]   Dp_out
);

  localparam int SW = NUM_DIGITS + 8;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } dec_t;

  // Inverse of the encoder's hex table; anything not listed is undecodable.
  function automatic dec_t decode_seg(input logic [6:0] seg);
    dec_t r;
    r.ok  = 1'b1;
    r.nib = 4'h0;
    case (seg)
      7'b0000001: r.nib = 4'h0;
      7'b1001111: r.nib = 4'h1;
      7'b0010010: r.nib = 4'h2;
      7'b0000110: r.nib = 4'h3;
      7'b1001100: r.nib = 4'h4;
      7'b0100100: r.nib = 4'h5;
      7'b0100000: r.nib = 4'h6;
      7'b0001111: r.nib = 4'h7;
      7'b0000000: r.nib = 4'h8;
      7'b0000100: r.nib = 4'h9;
      7'b0001000: r.nib = 4'hA;
      7'b1100000: r.nib = 4'hB;
      7'b0110001: r.nib = 4'hC;
      7'b1000010: r.nib = 4'hD;
      7'b0110000: r.nib = 4'hE;
      7'b0111000: r.nib = 4'hF;
      default:    r.ok  = 1'b0;
    endcase
    return r;
  endfunction

  // Number of anodes currently pulled low.
  function automatic int count_low(input logic [NUM_DIGITS-1:0] an);
    int n;
    n = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) n++;
    end
    return n;
  endfunction

  logic [SW-1:0]           in_sample;
  logic [SW-1:0]           samp_q, samp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    same_sample;
  logic                    settle_edge;
  int                      low_cnt;
  logic                    one_low;
  logic                    multi_low;
  logic                    blank_pat;
  dec_t                    dec;
  logic                    capture_en;
  logic                    err_set;
  logic                    frame_done;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  assign in_sample = {Anode_in, Seg_in};

  // Stability counter: it counts consecutive identical samples and saturates at the settle
  // threshold. The settle edge fires only once per dwell, when the count first reaches
  // the threshold.
  always_comb begin
    samp_d      = in_sample;
    same_sample = (in_sample == samp_q);
    if (same_sample) begin
      cnt_d = (cnt_q == SETTLE_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end else begin
      cnt_d = CNT_ONE;
    end
    settle_edge = (cnt_d == SETTLE_MAX) && (!same_sample || (cnt_q != SETTLE_MAX));
  end

  // Classify the settled sample: a good digit, a blank digit, a bad pattern or an anode conflict.
  always_comb begin
    low_cnt    = count_low(Anode_in);
    one_low    = (low_cnt == 1);
    multi_low  = (low_cnt > 1);
    dec        = decode_seg(Seg_in[7:1]);
    blank_pat  = (Seg_in[7:1] == 7'b1111111);
    capture_en = settle_edge && one_low && dec.ok;
    err_set    = settle_edge && (multi_low || (one_low && !dec.ok && !blank_pat));
  end

  // Frame assembly: publish the shadow word when the mask is full. A capture on the
  // same edge belongs to the new frame.
  always_comb begin
    shadow_d   = shadow_q;
    mask_d     = mask_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    frame_done = &mask_q;
    if (frame_done) begin
      value_d = shadow_q;
      valid_d = 1'b1;
      mask_d  = '0;
    end
    if (capture_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!Anode_in[i]) begin
          shadow_d[4*i +: 4] = dec.nib;
          mask_d[i]          = 1'b1;
        end
      end
    end
  end

  // Sticky error flag: a new error in the same cycle wins over a clear request.
  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (Err_clr) begin
      err_d = 1'b0;
    end
  end

  // State registers. The sample register resets to an idle bus, so the first real dwell differs from it.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      samp_q   <= '1;
      cnt_q    <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign Value_out  = value_q;
  assign Valid_out  = valid_q;
  assign Digit_mask = mask_q;
  assign Err_out    = err_q;

`ifdef DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0] dp_shadow_q, dp_shadow_d;
  logic [NUM_DIGITS-1:0] dp_out_q, dp_out_d;

  // Decimal points follow the nibbles: they are captured per digit and published with the frame.
  always_comb begin
    dp_shadow_d = dp_shadow_q;
    dp_out_d    = dp_out_q;
    if (frame_done) dp_out_d = dp_shadow_q;
    if (capture_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!Anode_in[i]) dp_shadow_d[i] = ~Seg_in[0];
      end
    end
  end

  // Decimal-point registers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      dp_shadow_q <= '0;
      dp_out_q    <= '0;
    end else begin
      dp_shadow_q <= dp_shadow_d;
      dp_out_q    <= dp_out_d;
    end
  end

  assign Dp_out = dp_out_q;
`else
  assign Dp_out = '0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: dwell-level reference model with a frame scoreboard.
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  typedef struct {
    logic [4*ND-1:0] value;
    logic [ND-1:0]   dp;
  } frame_t;

  logic            CLK = 1'b0;
  logic            Reset = 1'b1;
  logic [ND-1:0]   Anode_in;
  logic [7:0]      Seg_in;
  logic            Err_clr;
  logic [4*ND-1:0] Value_out;
  logic            Valid_out;
  logic [ND-1:0]   Digit_mask;
  logic            Err_out;
  logic [ND-1:0]   Dp_out;

  int compared   = 0;
  int mismatched = 0;

  frame_t        exp_q[$];
  frame_t        mon_f;
  logic [6:0]    hex_tbl[16];
  logic [3:0]    m_nib[ND];
  logic [ND-1:0] m_dp;
  logic [ND-1:0] m_mask;
  logic          m_err;
  logic [ND+7:0] m_prev;

  seg_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC)) dut (
    .CLK(CLK), .Reset(Reset), .Anode_in(Anode_in), .Seg_in(Seg_in), .Err_clr(Err_clr),
    .Value_out(Value_out), .Valid_out(Valid_out), .Digit_mask(Digit_mask),
    .Err_out(Err_out), .Dp_out(Dp_out)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic bit lookup(input logic [6:0] s, output logic [3:0] v);
    v = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (hex_tbl[k] == s) begin
        v = k[3:0];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One dwell: the bus is held for n cycles, optionally with Err_clr held high throughout.
  task automatic applyStimulus(input logic [ND-1:0] an, input logic [7:0] sg, input int n, input bit clr);
    int            lows;
    bit            cap, errset, ok;
    logic [3:0]    v;
    logic [ND-1:0] vis;
    frame_t        f;
    lows   = $countones(~an);
    cap    = 1'b0;
    errset = 1'b0;
    ok     = lookup(sg[7:1], v);
    if (n >= SC) begin
      if (lows == 1) begin
        if (ok) cap = 1'b1;
        else if (sg[7:1] != 7'h7F) errset = 1'b1;
      end else if (lows > 1) begin
        errset = 1'b1;
      end
    end
    if (cap) begin
      for (int i = 0; i < ND; i++) begin
        if (!an[i]) begin
          m_nib[i]  = v;
          m_dp[i]   = ~sg[0];
          m_mask[i] = 1'b1;
        end
      end
    end
    vis = m_mask;
    if (&m_mask) begin
      for (int i = 0; i < ND; i++) f.value[4*i +: 4] = m_nib[i];
`ifdef DP_CAPTURE_EN
      f.dp = m_dp;
`else
      f.dp = '0;
`endif
      exp_q.push_back(f);
      if (n > SC) vis = '0;
      m_mask = '0;
    end
    if (clr) m_err = errset && (n == SC);
    else     m_err = m_err | errset;
    m_prev = {an, sg};

    Anode_in = an;
    Seg_in   = sg;
    Err_clr  = clr;
    repeat (n) @(posedge CLK);
    #1;
    Err_clr = 1'b0;
    checkOutput("digit_mask", 32'(Digit_mask), 32'(vis));
    checkOutput("err_out", 32'(Err_out), 32'(m_err));
  endtask

  task automatic resetPulse();
    Anode_in = '1;
    Seg_in   = 8'hFF;
    Err_clr  = 1'b0;
    Reset    = 1'b0;
    #1;
    checkOutput("rst_value", 32'(Value_out), 32'h0);
    checkOutput("rst_valid", 32'(Valid_out), 32'h0);
    checkOutput("rst_mask", 32'(Digit_mask), 32'h0);
    checkOutput("rst_err", 32'(Err_out), 32'h0);
    checkOutput("rst_dp", 32'(Dp_out), 32'h0);
    m_mask = '0;
    m_err  = 1'b0;
    m_dp   = '0;
    m_prev = '1;
    for (int i = 0; i < ND; i++) m_nib[i] = 4'h0;
    @(posedge CLK);
    #1;
    Reset = 1'b1;
  endtask

  function automatic logic [7:0] segOf(input int v, input bit dp_lit);
    return {hex_tbl[v], ~dp_lit};
  endfunction

  // The scoreboard monitor: every Valid_out pulse must match the oldest expected frame.
  always @(negedge CLK) begin
    if (Valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_valid: got Value_out=%0h, expected no frame", Value_out);
      end else begin
        mon_f = exp_q.pop_front();
        checkOutput("frame_value", 32'(Value_out), 32'(mon_f.value));
        checkOutput("frame_dp", 32'(Dp_out), 32'(mon_f.dp));
      end
    end
  end

  initial begin
    logic [ND-1:0] an;
    logic [7:0]    sg;
    int            kind;
    hex_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    Anode_in = '1;
    Seg_in   = 8'hFF;
    Err_clr  = 1'b0;
    #2;
    resetPulse();

    // Basic scan of 1,2,3,4 produces 16'h4321.
    applyStimulus(4'b1110, 8'h9F, 6, 1'b0);
    applyStimulus(4'b1101, 8'h25, 6, 1'b0);
    applyStimulus(4'b1011, 8'h0D, 6, 1'b0);
    applyStimulus(4'b0111, 8'h99, 6, 1'b0);
    applyStimulus(4'b1111, 8'hFF, 3, 1'b0);

    // Dwells that are too short are not captured.
    applyStimulus(4'b1110, 8'h9F, 3, 1'b0);
    applyStimulus(4'b1101, 8'h25, 3, 1'b0);
    applyStimulus(4'b1111, 8'hFF, 3, 1'b0);

    // Blank patterns are ignored; a bad pattern raises the error; a clear drops it.
    applyStimulus(4'b1011, 8'hFF, 5, 1'b0);
    applyStimulus(4'b1011, 8'hFE, 10, 1'b0);
    applyStimulus(4'b1011, 8'h55, 5, 1'b0);
    applyStimulus(4'b1111, 8'hFF, 2, 1'b1);
    applyStimulus(4'b1011, 8'h55, 4, 1'b1);
    applyStimulus(4'b1111, 8'hFF, 2, 1'b1);

    // Two anodes low raises the error.
    applyStimulus(4'b0011, 8'h9F, 5, 1'b0);
    applyStimulus(4'b1111, 8'hFF, 2, 1'b1);

    // A reset in mid-frame discards the partial frame.
    applyStimulus(4'b1110, segOf(15, 1'b0), 5, 1'b0);
    applyStimulus(4'b1101, segOf(14, 1'b0), 5, 1'b0);
    resetPulse();
    applyStimulus(4'b1110, segOf(15, 1'b0), 5, 1'b0);
    applyStimulus(4'b1101, segOf(14, 1'b0), 5, 1'b0);
    applyStimulus(4'b1011, segOf(13, 1'b0), 5, 1'b0);
    applyStimulus(4'b0111, segOf(12, 1'b0), 5, 1'b0);
    applyStimulus(4'b1111, 8'hFF, 3, 1'b0);

    // The decimal point is lit on digit 1.
    applyStimulus(4'b1110, 8'h9F, 5, 1'b0);
    applyStimulus(4'b1101, 8'h24, 5, 1'b0);
    applyStimulus(4'b1011, 8'h0D, 5, 1'b0);
    applyStimulus(4'b0111, 8'h99, 5, 1'b0);
    applyStimulus(4'b1111, 8'hFF, 3, 1'b0);

    // Randomized dwells.
    for (int d = 0; d < 250; d++) begin
      do begin
        kind = $urandom_range(99);
        if (kind < 60) begin
          an = ~(ND'(1) << $urandom_range(ND-1));
          sg = {hex_tbl[$urandom_range(15)], 1'($urandom_range(1))};
        end else if (kind < 75) begin
          an = '1;
          sg = 8'hFF;
        end else if (kind < 83) begin
          an = ~(ND'(1) << $urandom_range(ND-1));
          sg = {7'h7F, 1'($urandom_range(1))};
        end else if (kind < 92) begin
          an = ~(ND'(1) << $urandom_range(ND-1));
          sg = 8'($urandom);
        end else begin
          do an = ND'($urandom); while ($countones(~an) < 2);
          sg = 8'($urandom);
        end
      end while ({an, sg} == m_prev);
      applyStimulus(an, sg, int'($urandom_range(8, 1)), ($urandom_range(9) == 0));
    end

    Anode_in = '1;
    Seg_in   = 8'hFF;
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge CLK);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("frames_pending", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
